// File: rtl/serial_arith_pkg.sv
// Shared state encoding for the bit-serial arithmetic units (subtractor now, adder later).
package serial_arith_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = a - b - bin, with borrow-out.
// Purely combinational; zero latency, no handshake.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b - bin), LSB first, one full-subtractor cell.
// Latency WIDTH+1 edges from accepted start to done; start is ignored while busy.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q, work_q, diff_q;
    logic               br_q, bout_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               fs_diff, fs_bout;
    logic               accept, last_bit;

    full_subtractor u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .diff (fs_diff),
        .bout (fs_bout)
    );

    assign accept   = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RUN;
            ST_RUN:  if (last_bit) state_d = ST_DONE;
            ST_DONE: state_d = accept ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_RUN);
        done = (state_q == ST_DONE);
    end

    // Result registers only load on the final bit, so diff/bout hold across a following RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            work_q <= '0;
            br_q   <= 1'b0;
            cnt_q  <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            br_q  <= bin;
            cnt_q <= '0;
        end else if (state_q == ST_RUN) begin
            a_q    <= a_q >> 1;
            b_q    <= b_q >> 1;
            br_q   <= fs_bout;
            work_q <= {fs_diff, work_q[WIDTH-1:1]};
            cnt_q  <= cnt_q + CNT_W'(1);
            if (last_bit) begin
                diff_q <= {fs_diff, work_q[WIDTH-1:1]};
                bout_q <= fs_bout;
            end
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: driver pushes expected results, monitor checks on done.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         bin = 1'b0;
    logic         busy, done, bout;
    logic [W-1:0] diff;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed { logic [W-1:0] d; logic bo; } exp_t;
    exp_t exp_q[$];

    logic [W-1:0] last_diff = '0;
    logic         last_bout = 1'b0;
    int           busy_run = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int   t;
        exp_t e;
        t    = int'(x) - int'(y) - int'(c);
        e.bo = (t < 0);
        e.d  = W'(t + 256);
        return e;
    endfunction

    // Issue one accepted start; operands are scrambled afterwards to prove capture.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        start = 1'b1; a = x; b = y; bin = c;
        exp_q.push_back(model(x, y, c));
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    endtask

    task automatic junk_start();
        start = 1'b1; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Returns the number of negedges until done is seen (0 on timeout).
    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 3 * W; i++) begin
            @(negedge clk);
            if (done) begin n = i; break; end
        end
        if (n == 0) begin
            miscompares++;
            vectors++;
            $display("FAIL done_timeout: no done within %0d cycles", 3 * W);
        end
    endtask

    // Monitor: compares results on done, and checks busy length, exclusivity and result stability.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_diff = '0; last_bout = 1'b0; busy_run = 0;
            end else begin
                if (busy && done) check("busy_done_overlap", 1, 0);
                if (busy) busy_run++;
                if (done) begin
                    check("busy_cycles", busy_run, W);
                    busy_run = 0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("diff", diff, e.d);
                        check("bout", bout, e.bo);
                    end
                    last_diff = diff; last_bout = bout;
                end else begin
                    check("diff_stable", {bout, diff}, {last_bout, last_diff});
                end
            end
        end
    end

    initial begin
        int n;
        #3;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        issue(8'h3C, 8'h15, 1'b0);
        wait_done(n);
        check("latency", n, W + 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);

        issue(8'h00, 8'h01, 1'b0); wait_done(n);
        issue(8'h80, 8'h7F, 1'b1); wait_done(n);
        issue(8'h10, 8'h10, 1'b1); wait_done(n);
        @(negedge clk);

        // Start mid-RUN is ignored; start in DONE cycle is taken back-to-back.
        issue(8'h3C, 8'h15, 1'b0);
        repeat (2) @(negedge clk);
        junk_start();
        wait_done(n);
        issue(8'h05, 8'h03, 1'b0);
        wait_done(n);
        check("b2b_latency", n, W + 1);
        @(negedge clk);

        // Asynchronous reset in the middle of RUN.
        issue(8'hA5, 8'h5A, 1'b1);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_diff", diff, 0);
        check("mid_rst_bout", bout, 0);
        @(negedge clk);
        check("mid_rst_no_done", done, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {busy, done}, 0);
        issue(8'h3C, 8'h15, 1'b0); wait_done(n);
        @(negedge clk);

        for (int k = 0; k < 1000; k++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom));
            if ($urandom_range(3) == 0) begin
                repeat ($urandom_range(1, 4)) @(negedge clk);
                junk_start();
            end
            wait_done(n);
            if ($urandom_range(1) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor: computes diff = a - b - bin, one bit per clock, LSB first.
- Uses a single full-subtractor cell and a registered borrow; it is the subtraction counterpart of the combinational adder cells.
- Area-lean arithmetic unit for datapaths that can tolerate WIDTH-cycle latency; start/busy/done handshake toward the controlling FSM.

Parameters:
- WIDTH, 8, operand and result width in bits (WIDTH >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- bin  input  1  borrow-in; captured on accepted start.
- busy  output  1  high while state == RUN.
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  result (a - b - bin) mod 2^WIDTH.
- bout  output  1  final borrow-out (1 when a < b + bin, unsigned).

Behaviour:
- Reset (async, immediate): state=IDLE, busy=0, done=0, diff=0, bout=0, internal shift registers, borrow and counter cleared.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge k -> latch a, b into shift registers, borrow<=bin, cnt<=0, go RUN.
- RUN: each edge processes bit 0 of the shift registers:
  - d = a0 ^ b0 ^ br
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
  - d enters the MSB of the work register; a/b shift right; cnt++.
- After the bit at cnt == WIDTH-1, go DONE, diff <= completed work register, bout <= br_next.
- Latency: start at edge k -> RUN on edges k+1..k+WIDTH -> done=1 in the cycle after edge k+WIDTH (WIDTH+1 edges from start).
- DONE: done=1 for exactly one cycle.
  - If start=1, accept new operands as in IDLE and go RUN (back-to-back).
  - Otherwise go IDLE.
- busy=1 exactly WIDTH cycles per operation; done and busy are never high together.
- start while RUN: ignored, no queuing; operands in flight are unaffected.
- diff/bout are registered outputs. They hold the last result from completion until the next completion; they are not disturbed during a following RUN.
- Input operand changes outside the accepting edge have no effect.
- rst mid-RUN: operation abandoned, no done pulse, outputs go to reset values.
- Counter width $clog2(WIDTH); no overflow, since the count terminates at WIDTH-1.

Decomposition:
- Shared package/header serial_arith_pkg: state encoding localparams (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2). A future serial_adder reuses the same encoding.
- Sub-module full_subtractor (inputs a, b, bin; outputs diff, bout; purely combinational), instantiated once per bit-step.
- Top: FSM, counter, shift registers, result registers.

Test Plan:
- WIDTH=8, a=0x3C, b=0x15, bin=0, start pulse -> busy high 8 cycles; done once at edge 9; diff=0x27, bout=0.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1 (wrap-around underflow).
- a=0x80, b=0x7F, bin=1 -> diff=0x00, bout=0; then a=0x10, b=0x10, bin=1 -> diff=0xFF, bout=1.
- First op a=0x3C, b=0x15; pulse start with a=0xFF, b=0x00 mid-RUN -> ignored, diff=0x27. Start asserted in the DONE cycle with a=0x05, b=0x03 -> accepted with no IDLE gap, diff=0x02, bout=0 after 8 more cycles.
- rst asserted asynchronously at RUN cycle 4 -> busy, done, diff, bout go to 0 before the next edge; no done pulse. A new start after rst release yields the correct result.
- Randomized 1000 ops against the reference model (a - b - bin) mod 256 and borrow flag; check diff stability between completions.
